// File: rtl/keccak_round_scheduler_if.sv
// rtl/keccak_round_scheduler_if.sv - host/stage-side bundle for the Keccak round scheduler
interface keccak_round_scheduler_if #(
    parameter int NUM_STAGES = 5,
    parameter int RND_W      = 5,
    parameter int STG_W      = 3
);
    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_done;
    logic [NUM_STAGES-1:0] stage_en;
    logic [STG_W-1:0]      stage_idx;
    logic [RND_W-1:0]      cnt24_value;
    logic                  last_round;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, abort, stage_done,
        input  stage_en, stage_idx, cnt24_value, last_round, busy, done, err
    );

    modport slave (
        input  start, abort, stage_done,
        output stage_en, stage_idx, cnt24_value, last_round, busy, done, err
    );
endinterface

// File: rtl/keccak_round_scheduler.sv
// rtl/keccak_round_scheduler.sv - sequences theta/rho/pi/chi/addRC over 24 rounds
// Optional per-stage watchdog enabled by SCHED_TIMEOUT_EN.
module keccak_round_scheduler #(
    parameter int NUM_STAGES  = 5,
    parameter int NUM_ROUNDS  = 24,
    parameter int RND_W       = 5,
    parameter int STG_W       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    keccak_round_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FIN} state_t;

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

    state_t                state, state_nxt;
    logic [STG_W-1:0]      stage, stage_nxt;
    logic [RND_W-1:0]      round, round_nxt;
    logic [NUM_STAGES-1:0] done_q;
    logic                  start_q;
    logic                  hit;

    // Inputs are registered, so start and stage_done act one edge after they are sampled.
    assign hit = done_q[stage];

`ifdef SCHED_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             err_q, err_nxt;
    logic             expired;

    assign expired = (tmr == TMR_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            stage   <= '0;
            round   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tmr     <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            stage   <= stage_nxt;
            round   <= round_nxt;
            done_q  <= bus.stage_done;
            start_q <= (state == S_IDLE) && bus.start && !bus.abort;
`ifdef SCHED_TIMEOUT_EN
            tmr     <= tmr_nxt;
            err_q   <= err_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        round_nxt = round;
`ifdef SCHED_TIMEOUT_EN
        err_nxt   = err_q;
        tmr_nxt   = (state == S_RUN) ? tmr + TMR_W'(1) : '0;
`endif
        if (bus.abort) begin
            state_nxt = S_IDLE;
            stage_nxt = '0;
            round_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_q) begin
                        state_nxt = S_RUN;
                        stage_nxt = '0;
                        round_nxt = '0;
`ifdef SCHED_TIMEOUT_EN
                        err_nxt   = 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (hit) begin
                        state_nxt = S_GAP;
`ifdef SCHED_TIMEOUT_EN
                    end else if (expired) begin
                        state_nxt = S_IDLE;
                        stage_nxt = '0;
                        err_nxt   = 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    if (stage != LAST_STG) begin
                        state_nxt = S_RUN;
                        stage_nxt = stage + STG_W'(1);
                    end else if (round != LAST_RND) begin
                        state_nxt = S_RUN;
                        stage_nxt = '0;
                        round_nxt = round + RND_W'(1);
                    end else begin
                        state_nxt = S_FIN;
                        stage_nxt = '0;
                    end
                end
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.stage_en    = (state == S_RUN) ? (NUM_STAGES'(1) << stage) : '0;
    assign bus.stage_idx   = stage;
    assign bus.cnt24_value = round;
    assign bus.busy        = (state == S_RUN) || (state == S_GAP);
    assign bus.last_round  = bus.busy && (round == LAST_RND);
    assign bus.done        = (state == S_FIN);
`ifdef SCHED_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_keccak_round_scheduler.sv
// tb/tb_keccak_round_scheduler.sv - randomized bench for keccak_round_scheduler with a timing model
module tb_keccak_round_scheduler;
    localparam int NS = 5;
    localparam int NR = 24;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    keccak_round_scheduler_if #(.NUM_STAGES(NS), .RND_W(5), .STG_W(3)) bus ();

    keccak_round_scheduler #(
        .NUM_STAGES(NS), .NUM_ROUNDS(NR), .RND_W(5), .STG_W(3), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_en"},   bus.stage_en, 0);
        chk({tag, "_idx"},  bus.stage_idx, 0);
        chk({tag, "_cnt"},  bus.cnt24_value, 0);
        chk({tag, "_last"}, bus.last_round, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"},  bus.err, 0);
    endtask

    // Model: each stage occupies (response latency + 1) enabled cycles plus one gap cycle;
    // done follows 1 + sum of those costs cycles after the start edge.
    task automatic run(input bit tied, input int abort_r, input int abort_s, input int rst_r,
                       input int glitch_r, input int glitch_s, input int hang_s, input int slow_s);
        int er = 0, es = 0, len = 0, lat = 0, since = 0, exp_cyc = 1;
        logic [NS-1:0] prev = '0;
        bus.stage_done = tied ? '1 : '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_edge_en", bus.stage_en, 0);
        for (int k = 0; k < 3000; k++) begin
            tick();
            bus.start = 1'b0;
            since++;
            if (since == 1) chk("start_latency", bus.stage_en, 1);
            if (bus.done) begin
                chk("done_cycle", since, exp_cyc);
                if (tied) chk("done_241", since, 241);
                chk("done_cnt", bus.cnt24_value, NR - 1);
                chk("done_busy", bus.busy, 0);
                chk("done_err", bus.err, 0);
                tick();
                chk("done_pulse", bus.done, 0);
                chk("idle_busy", bus.busy, 0);
                chk("idle_cnt", bus.cnt24_value, NR - 1);
                return;
            end
            if (bus.stage_en != '0) begin
                chk("en_onehot", bus.stage_en, 1 << es);
                if (prev == '0) begin
                    chk("rise_cnt", bus.cnt24_value, er);
                    chk("rise_idx", bus.stage_idx, es);
                    chk("rise_last", bus.last_round, er == NR - 1);
                    chk("rise_busy", bus.busy, 1);
                    chk("rise_err", bus.err, 0);
                    len = 0;
                    lat = tied ? 0 : ((er == 0 && es == slow_s) ? TO - 1 : int'($urandom_range(1, 4)));
                    if (er == abort_r && es == abort_s) begin
                        bus.abort = 1'b1;
                        tick();
                        bus.abort = 1'b0;
                        chk("abort_en", bus.stage_en, 0);
                        chk("abort_busy", bus.busy, 0);
                        chk("abort_cnt", bus.cnt24_value, 0);
                        chk("abort_done", bus.done, 0);
                        tick();
                        chk("abort_nodone", bus.done, 0);
                        return;
                    end
                    if (er == rst_r && es == 0) begin
                        rst = 1'b0;
                        bus.start = 1'b1;
                        bus.abort = 1'b1;
                        tick();
                        rst = 1'b1;
                        bus.start = 1'b0;
                        bus.abort = 1'b0;
                        chk_idle_reset("midrst");
                        tick();
                        chk("midrst_stay_idle", bus.busy, 0);
                        return;
                    end
                    if (er == glitch_r && es == glitch_s) bus.start = 1'b1;
                end
                len++;
            end else if (prev != '0) begin
                if (er == 0 && es == hang_s) begin
                    chk("to_len", len, TO);
                    chk("to_err", bus.err, 1);
                    chk("to_busy", bus.busy, 0);
                    chk("to_done", bus.done, 0);
                    tick();
                    chk("to_nodone", bus.done, 0);
                    chk("to_sticky", bus.err, 1);
                    return;
                end
                chk("en_len", len, tied ? 1 : lat + 1);
                chk("gap_busy", bus.busy, 1);
                exp_cyc += len + 1;
                es++;
                if (es == NS) begin
                    es = 0;
                    er++;
                end
            end
            prev = bus.stage_en;
            if (tied) begin
                bus.stage_done = '1;
            end else if (bus.stage_en == '0) begin
                bus.stage_done = '0;
            end else begin
                bus.stage_done = NS'(1) << ((es + int'($urandom_range(1, NS - 1))) % NS);
                if (len >= lat && !(er == 0 && es == hang_s))
                    bus.stage_done = bus.stage_done | (NS'(1) << es);
            end
        end
        chk("watchdog_expired", 0, 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stage_done = '0;
        rst = 1'b0;
        repeat (3) tick();
        chk_idle_reset("reset");
        rst = 1'b1;
        tick();
        chk("post_reset_busy", bus.busy, 0);

        run(1'b1, -1, -1, -1, -1, -1, -1, -1);
        run(1'b0, -1, -1, -1, -1, -1, -1, -1);
        run(1'b0,  7,  3, -1,  5,  2, -1, -1);
        run(1'b1, -1, -1, -1,  5,  2, -1, -1);
        run(1'b1, -1, -1, 12, -1, -1, -1, -1);
        run(1'b1, -1, -1, -1, -1, -1, -1, -1);
`ifdef SCHED_TIMEOUT_EN
        run(1'b0, -1, -1, -1, -1, -1,  2, -1);
        run(1'b0, -1, -1, -1, -1, -1, -1, -1);
        run(1'b0, -1, -1, -1, -1, -1, -1,  1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
